// File: rtl/dio_image_loader.sv
// Host download engine: packs ioctl bytes into 16-bit words, writes them into
// per-index SDRAM regions inside DIO bus slots, and tracks floppy image status.
module dio_image_loader #(
  parameter int unsigned NUM_DRIVES   = 2,
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned REGION_SHIFT = 19,
  parameter int unsigned DS_WORDS     = 409600,
  parameter int unsigned SS_WORDS     = 204800
) (
  input  logic                  clk_sys,
  input  logic                  n_reset,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  ioctl_wait,
  input  logic                  bus_slot,
  output logic                  mem_active,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [15:0]           mem_data,
  input  logic [NUM_DRIVES-1:0] disk_eject,
  output logic [NUM_DRIVES-1:0] disk_inserted,
  output logic [NUM_DRIVES-1:0] disk_ds,
  output logic                  size_error,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, GAP, SLOT, WRITE} state_t;

  localparam logic [7:0] MAX_IDX = 8'(NUM_DRIVES);

  state_t      state, state_nx;
  logic        dl_prev;
  logic [7:0]  cur_index;
  logic [7:0]  hi_byte;
  logic [23:0] hi_waddr;
  logic        hi_valid;
  logic [25:0] max_addr;
  logic        flush_req, flush_busy;

  logic        rise, fall, idx_valid, strobe, odd_strobe, even_strobe;
  logic        flush_load, word_done, word_accept, flush_pending;
  logic [7:0]  new_index;
  logic [23:0] new_waddr;
  logic [15:0] new_data;
  logic [31:0] mapped;
  logic [25:0] addr_p1, max_base;
  logic [26:0] words;
  logic        ds_size, ss_size;

  assign rise        = ioctl_download & ~dl_prev;
  assign fall        = ~ioctl_download & dl_prev;
  assign idx_valid   = (ioctl_index <= MAX_IDX);
  assign strobe      = ioctl_download & ioctl_wr & idx_valid;
  assign odd_strobe  = strobe & ioctl_addr[0];
  assign even_strobe = strobe & ~ioctl_addr[0];

  // A pending tail flush takes the FSM ahead of any new strobe.
  assign flush_load    = flush_req & (state == IDLE);
  assign word_done     = odd_strobe | flush_load;
  assign word_accept   = word_done & (state == IDLE);
  assign flush_pending = flush_req | flush_busy;

  assign new_index = flush_load ? cur_index : ioctl_index;
  assign new_waddr = flush_load ? hi_waddr : ioctl_addr[24:1];
  assign new_data  = flush_load ? {hi_byte, 8'hFF} : {hi_byte, ioctl_dout};
  assign mapped    = (32'(new_index) << REGION_SHIFT) + 32'(new_waddr);

  assign addr_p1  = {1'b0, ioctl_addr} + 26'd1;
  assign max_base = rise ? '0 : max_addr;
  assign words    = ({1'b0, max_addr} + 27'd1) >> 1;
  assign ds_size  = (words == 27'(DS_WORDS));
  assign ss_size  = (words == 27'(SS_WORDS));

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (word_done) state_nx = GAP;
      GAP:   if (!bus_slot) state_nx = SLOT;
      SLOT:  if (bus_slot)  state_nx = WRITE;
      WRITE: if (!bus_slot) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SLOT is only left on the slot's first high cycle, so writing there too
  // makes mem_we cover every cycle of the claimed slot.
  assign mem_we     = bus_slot & ((state == SLOT) | (state == WRITE));
  assign ioctl_wait = (state != IDLE);
  assign mem_active = (ioctl_download | flush_pending | (state != IDLE)) & bus_slot;

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      dl_prev    <= 1'b0;
      cur_index  <= '0;
      hi_byte    <= '0;
      hi_waddr   <= '0;
      hi_valid   <= 1'b0;
      max_addr   <= '0;
      flush_req  <= 1'b0;
      flush_busy <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      dl_prev <= ioctl_download;
      if (ioctl_download) cur_index <= ioctl_index;

      if (even_strobe) begin
        hi_byte  <= ioctl_dout;
        hi_waddr <= ioctl_addr[24:1];
        hi_valid <= 1'b1;
      end else if (odd_strobe || fall) begin
        hi_valid <= 1'b0;
      end

      if (strobe && (addr_p1 > max_base)) max_addr <= addr_p1;
      else                                max_addr <= max_base;

      if (fall && hi_valid) flush_req <= 1'b1;
      else if (flush_load)  flush_req <= 1'b0;

      if (flush_load)                           flush_busy <= 1'b1;
      else if ((state == WRITE) && !bus_slot)   flush_busy <= 1'b0;

      if (word_accept) begin
        mem_addr <= mapped[ADDR_W-1:0];
        mem_data <= new_data;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      disk_inserted <= '0;
      disk_ds       <= '0;
      size_error    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (rise) begin
        overrun <= 1'b0;
        if ((ioctl_index != 8'd0) && idx_valid) size_error <= 1'b0;
      end
      if (odd_strobe && ((state != IDLE) || flush_load)) overrun <= 1'b1;
      if (fall && (cur_index != 8'd0) && (cur_index <= MAX_IDX))
        size_error <= ~(ds_size | ss_size);

      // Eject is applied last so it overrides a same-cycle size latch.
      for (int unsigned j = 0; j < NUM_DRIVES; j++) begin
        if (rise && (ioctl_index == 8'(j + 1))) begin
          disk_inserted[j] <= 1'b0;
          disk_ds[j]       <= 1'b0;
        end
        if (fall && (cur_index == 8'(j + 1))) begin
          disk_inserted[j] <= ds_size | ss_size;
          disk_ds[j]       <= ds_size;
        end
        if (disk_eject[j]) begin
          disk_inserted[j] <= 1'b0;
          disk_ds[j]       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dio_image_loader.sv
// Directed bench for dio_image_loader: ROM load, DS/SS images, odd tail flush,
// eject, overrun, invalid index and reset during a pending write.
module tb_dio_image_loader;

  logic        clk_sys = 1'b0;
  logic        n_reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        bus_slot = 1'b0;
  logic        mem_active, mem_we;
  logic [21:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  disk_eject = '0;
  logic [1:0]  disk_inserted, disk_ds;
  logic        size_error, overrun;

  int checks = 0;
  int errors = 0;

  logic        slot_en = 1'b0;
  logic        slot_hold = 1'b0;
  logic [31:0] cyc = '0;

  logic [21:0] w_addr [16];
  logic [15:0] w_data [16];
  int          w_len  [16];
  int          wcount = 0;
  logic        in_w = 1'b0;
  int          run = 0;
  logic [21:0] cur_a;
  logic [15:0] cur_d;

  dio_image_loader #(
    .NUM_DRIVES(2), .ADDR_W(22), .REGION_SHIFT(19),
    .DS_WORDS(409600), .SS_WORDS(204800)
  ) dut (
    .clk_sys(clk_sys), .n_reset(n_reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .bus_slot(bus_slot),
    .mem_active(mem_active), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .disk_eject(disk_eject), .disk_inserted(disk_inserted), .disk_ds(disk_ds),
    .size_error(size_error), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // Slot generator: 4 cycles high every 8 when enabled, or held high.
  initial begin
    forever begin
      @(posedge clk_sys); #1;
      cyc = cyc + 1;
      bus_slot = slot_hold | (slot_en & cyc[2]);
    end
  end

  // Write recorder: one entry per contiguous mem_we burst.
  always @(negedge clk_sys) begin
    if (mem_we) begin
      if (!in_w) begin
        cur_a = mem_addr;
        cur_d = mem_data;
        run = 0;
        in_w = 1'b1;
      end
      run = run + 1;
    end else if (in_w) begin
      if (wcount < 16) begin
        w_addr[wcount] = cur_a;
        w_data[wcount] = cur_d;
        w_len[wcount]  = run;
      end
      wcount = wcount + 1;
      in_w = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit honor_wait);
    int n = 0;
    while (honor_wait && ioctl_wait && n < 200) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (n >= 200) chk("wait_timeout", 32'd1, 32'd0);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (wcount < target && n < 300) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (n >= 300) chk("write_timeout", 32'(wcount), 32'(target));
  endtask

  task automatic check_write(input string tag, input int i, input logic [21:0] a, input logic [15:0] d);
    chk({tag, "_addr"}, 32'(w_addr[i]), 32'(a));
    chk({tag, "_data"}, 32'(w_data[i]), 32'(d));
    chk({tag, "_len"},  32'(w_len[i]),  32'd4);
  endtask

  initial begin
    int base;

    // Reset state
    tick(3);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_active", 32'(mem_active), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_ins", 32'(disk_inserted), 32'd0);
    chk("rst_flags", 32'({size_error, overrun, disk_ds}), 32'd0);
    n_reset = 1'b1;
    slot_en = 1'b1;
    tick(2);

    // ROM load, index 0
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick(1);
    send_byte(25'd0, 8'h12, 1'b1);
    chk("rom_wait_idle", 32'(ioctl_wait), 32'd0);
    send_byte(25'd1, 8'h34, 1'b1);
    chk("rom_wait_hi0", 32'(ioctl_wait), 32'd1);
    send_byte(25'd2, 8'h56, 1'b1);
    send_byte(25'd3, 8'h78, 1'b1);
    chk("rom_wait_hi1", 32'(ioctl_wait), 32'd1);
    wait_writes(2);
    ioctl_download = 1'b0;
    tick(2);
    check_write("rom_w0", 0, 22'h000000, 16'h1234);
    check_write("rom_w1", 1, 22'h000001, 16'h5678);
    chk("rom_wait_end", 32'(ioctl_wait), 32'd0);
    chk("rom_ins", 32'(disk_inserted), 32'd0);

    // Double-sided image on index 2 (first and last byte pairs only)
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    tick(1);
    send_byte(25'd0, 8'hA1, 1'b1);
    send_byte(25'd1, 8'hB2, 1'b1);
    send_byte(25'd819198, 8'hC3, 1'b1);
    send_byte(25'd819199, 8'hD4, 1'b1);
    wait_writes(4);
    ioctl_download = 1'b0;
    tick(2);
    check_write("ds_w0", 2, 22'h100000, 16'hA1B2);
    check_write("ds_w1", 3, 22'h163FFF, 16'hC3D4);
    chk("ds_ins", 32'(disk_inserted), 32'h2);
    chk("ds_ds", 32'(disk_ds), 32'h2);
    chk("ds_err", 32'(size_error), 32'd0);

    // Odd tail on index 1
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick(1);
    send_byte(25'd0, 8'hAA, 1'b1);
    send_byte(25'd1, 8'hBB, 1'b1);
    send_byte(25'd2, 8'hCC, 1'b1);
    wait_writes(5);
    ioctl_download = 1'b0;
    wait_writes(6);
    tick(2);
    check_write("tail_w0", 4, 22'h080000, 16'hAABB);
    check_write("tail_w1", 5, 22'h080001, 16'hCCFF);
    chk("tail_err", 32'(size_error), 32'd1);
    chk("tail_ins", 32'(disk_inserted), 32'h2);
    chk("tail_ds", 32'(disk_ds), 32'h2);

    // Single-sided image on drive 1, then eject
    for (int pass = 0; pass < 2; pass++) begin
      base = 6 + 2 * pass;
      ioctl_index = 8'd1; ioctl_download = 1'b1;
      tick(1);
      send_byte(25'd0, 8'h01, 1'b1);
      send_byte(25'd1, 8'h02, 1'b1);
      send_byte(25'd409598, 8'h03, 1'b1);
      send_byte(25'd409599, 8'h04, 1'b1);
      wait_writes(base + 2);
      if (pass == 0) begin
        ioctl_download = 1'b0;
        tick(2);
        check_write("ss_w1", 7, 22'h0B1FFF, 16'h0304);
        chk("ss_ins", 32'(disk_inserted), 32'h3);
        chk("ss_ds", 32'(disk_ds), 32'h2);
        chk("ss_err", 32'(size_error), 32'd0);
        disk_eject = 2'b01;
        tick(1);
        disk_eject = 2'b00;
        tick(1);
        chk("eject_ins", 32'(disk_inserted), 32'h2);
        chk("eject_ds", 32'(disk_ds), 32'h2);
      end else begin
        ioctl_download = 1'b0;
        disk_eject = 2'b01;
        tick(1);
        disk_eject = 2'b00;
        tick(1);
        chk("eject_fall_ins", 32'(disk_inserted), 32'h2);
        chk("eject_fall_err", 32'(size_error), 32'd0);
      end
    end

    // Overrun: second word completes while first is parked in GAP
    slot_hold = 1'b1;
    tick(2);
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick(1);
    send_byte(25'd0, 8'h11, 1'b1);
    send_byte(25'd1, 8'h22, 1'b1);
    send_byte(25'd2, 8'h33, 1'b0);
    send_byte(25'd3, 8'h44, 1'b0);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_wait", 32'(ioctl_wait), 32'd1);
    slot_hold = 1'b0;
    wait_writes(11);
    tick(30);
    ioctl_download = 1'b0;
    tick(2);
    chk("ovr_count", 32'(wcount), 32'd11);
    check_write("ovr_w", 10, 22'h000000, 16'h1122);

    // Invalid index
    ioctl_index = 8'd5; ioctl_download = 1'b1;
    tick(2);
    chk("inv_ovr_clr", 32'(overrun), 32'd0);
    send_byte(25'd0, 8'h55, 1'b1);
    send_byte(25'd1, 8'h66, 1'b1);
    chk("inv_wait", 32'(ioctl_wait), 32'd0);
    tick(20);
    ioctl_download = 1'b0;
    tick(2);
    chk("inv_count", 32'(wcount), 32'd11);
    chk("inv_ins", 32'(disk_inserted), 32'h2);

    // Reset while a word waits in SLOT
    slot_en = 1'b0;
    tick(3);
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick(1);
    send_byte(25'd0, 8'hAB, 1'b1);
    send_byte(25'd1, 8'hCD, 1'b1);
    tick(1);
    chk("rmw_wait_pre", 32'(ioctl_wait), 32'd1);
    n_reset = 1'b0;
    #1;
    chk("rmw_wait", 32'(ioctl_wait), 32'd0);
    chk("rmw_we", 32'(mem_we), 32'd0);
    chk("rmw_ins", 32'(disk_inserted), 32'd0);
    chk("rmw_ds", 32'(disk_ds), 32'd0);
    tick(1);
    ioctl_download = 1'b0;
    tick(1);
    n_reset = 1'b1;
    slot_en = 1'b1;
    tick(40);
    chk("rmw_no_write", 32'(wcount), 32'd11);
    chk("rmw_wait_post", 32'(ioctl_wait), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
